// File: rtl/detect_burst_4k.sv
// Coalesces a stream of beat addresses into AXI-style bursts.
// Bursts never cross a 2^BoundaryLog byte boundary and are flushed after an idle timeout.
module detect_burst_4k #(
  parameter int AddrWidth         = 64,
  parameter int DataWidthBytesLog = 6,
  parameter int WaitTimeWidth     = 4,
  parameter int BurstLenWidth     = 8,
  parameter int BoundaryLog       = 12
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [WaitTimeWidth-1:0]           max_wait_time,
  input  logic [BurstLenWidth-1:0]           max_burst_len,
  input  logic [AddrWidth-1:0]               addr_dout,
  input  logic                               addr_empty_n,
  output logic                               addr_read,
  output logic [BurstLenWidth+AddrWidth-1:0] addr_din,
  input  logic                               addr_full_n,
  output logic                               addr_write,
  output logic [BurstLenWidth-1:0]           burst_len_din,
  input  logic                               burst_len_full_n,
  output logic                               burst_len_write
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [AddrWidth-1:0] Beat = {{(AddrWidth-1){1'b0}}, 1'b1} << DataWidthBytesLog;

  state_t                   state;
  logic [AddrWidth-1:0]     base;
  logic [AddrWidth-1:0]     next_addr;
  logic [BurstLenWidth-1:0] len;
  logic [WaitTimeWidth-1:0] wait_cnt;

  logic extend;
  logic flush;
  logic emit;

  always_comb begin
    extend = 1'b0;
    flush  = 1'b0;
    emit   = 1'b0;
    if (state == ACCUM) begin
      extend = addr_empty_n && (addr_dout == next_addr) && (len < max_burst_len)
               && (next_addr[BoundaryLog-1:0] != '0);
      flush  = (addr_empty_n && !extend) || (!addr_empty_n && (wait_cnt >= max_wait_time));
      emit   = flush && addr_full_n && burst_len_full_n;
    end
  end

  // Handshakes are gated by rst_n so they read as zero while reset is held.
  always_comb begin
    addr_read       = 1'b0;
    addr_write      = 1'b0;
    burst_len_write = 1'b0;
    if (rst_n) begin
      if (state == IDLE) addr_read = addr_empty_n;
      else               addr_read = extend || (emit && addr_empty_n);
      addr_write      = emit;
      burst_len_write = emit;
    end
  end

  assign addr_din      = {len, base};
  assign burst_len_din = len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      next_addr <= '0;
      len       <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (addr_empty_n) begin
            base      <= addr_dout;
            next_addr <= addr_dout + Beat;
            len       <= '0;
            wait_cnt  <= '0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (extend) begin
            len       <= len + 1'b1;
            next_addr <= next_addr + Beat;
            wait_cnt  <= '0;
          end else if (emit) begin
            // Back-to-back: the address that broke the burst opens the next one.
            if (addr_empty_n) begin
              base      <= addr_dout;
              next_addr <= addr_dout + Beat;
              len       <= '0;
              wait_cnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (!addr_empty_n && (wait_cnt < max_wait_time) && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detect_burst_4k.sv
// Bench for detect_burst_4k: directed scenarios plus randomized streams checked
// against a list-level burst segmentation model.
module tb_detect_burst_4k;
  localparam int AW = 64;
  localparam int LW = 8;
  localparam int BL = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    max_wait_time;
  logic [LW-1:0] max_burst_len;
  logic [AW-1:0] addr_dout;
  logic          addr_empty_n;
  logic          addr_read;
  logic [LW+AW-1:0] addr_din;
  logic          addr_full_n;
  logic          addr_write;
  logic [LW-1:0] burst_len_din;
  logic          burst_len_full_n;
  logic          burst_len_write;

  always #5 clk = ~clk;

  detect_burst_4k #(
    .AddrWidth(64), .DataWidthBytesLog(6), .WaitTimeWidth(4),
    .BurstLenWidth(8), .BoundaryLog(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .max_wait_time(max_wait_time), .max_burst_len(max_burst_len),
    .addr_dout(addr_dout), .addr_empty_n(addr_empty_n), .addr_read(addr_read),
    .addr_din(addr_din), .addr_full_n(addr_full_n), .addr_write(addr_write),
    .burst_len_din(burst_len_din), .burst_len_full_n(burst_len_full_n),
    .burst_len_write(burst_len_write)
  );

  logic [AW-1:0] q[$];
  int            gap[$];
  logic [AW-1:0] popped[$];
  logic [LW-1:0] got_len[$];
  logic [AW-1:0] got_base[$];
  logic [LW-1:0] exp_len[$];
  logic [AW-1:0] exp_base[$];
  int pop_cyc[$];
  int emit_cyc[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int bp_pct = 0;
  int full_force = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] gl(input int i);
    if (i < got_len.size()) return 128'(got_len[i]);
    return 'x;
  endfunction

  function automatic logic [127:0] gb(input int i);
    if (i < got_base.size()) return 128'(got_base[i]);
    return 'x;
  endfunction

  function automatic int pc(input int i);
    if (i < pop_cyc.size()) return pop_cyc[i];
    return -1000;
  endfunction

  function automatic int ec(input int i);
    if (i < emit_cyc.size()) return emit_cyc[i];
    return -1000;
  endfunction

  // One clock of the input FIFO model; outputs are sampled mid-cycle, away from posedge.
  task automatic tick();
    @(negedge clk);
    addr_empty_n = (q.size() > 0) ? (gap[0] == 0) : 1'b0;
    addr_dout    = addr_empty_n ? q[0] : {$urandom, $urandom};
    if (full_force > 0) begin
      addr_full_n = 1'b0;
      full_force--;
    end else begin
      addr_full_n = ($urandom_range(99) >= bp_pct);
    end
    burst_len_full_n = ($urandom_range(99) >= bp_pct);
    #2;
    chk("read_gated", addr_read & ~addr_empty_n, 0);
    chk("write_pair", addr_write, burst_len_write);
    if (addr_write === 1'b1) begin
      got_len.push_back(addr_din[LW+AW-1:AW]);
      got_base.push_back(addr_din[AW-1:0]);
      emit_cyc.push_back(cyc);
      chk("len_field", burst_len_din, addr_din[LW+AW-1:AW]);
    end
    if (addr_read === 1'b1 && q.size() > 0) begin
      popped.push_back(q[0]);
      void'(q.pop_front());
      void'(gap.pop_front());
      pop_cyc.push_back(cyc);
    end else if (q.size() > 0 && gap[0] > 0) begin
      gap[0] = gap[0] - 1;
    end
    cyc++;
  endtask

  task automatic push(input logic [AW-1:0] a, input int g);
    q.push_back(a);
    gap.push_back(g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    addr_empty_n = 1'b1;
    addr_dout = 64'h1234_0040;
    addr_full_n = 1'b1;
    burst_len_full_n = 1'b1;
    #2;
    chk("rst_read", addr_read, 0);
    chk("rst_write", addr_write, 0);
    chk("rst_blen_write", burst_len_write, 0);
    chk("rst_din", addr_din, 0);
    chk("rst_blen", burst_len_din, 0);
    @(negedge clk);
    addr_empty_n = 1'b0;
    rst_n = 1'b1;
    q.delete(); gap.delete(); popped.delete();
    got_len.delete(); got_base.delete(); pop_cyc.delete(); emit_cyc.delete();
    bp_pct = 0;
    full_force = 0;
  endtask

  task automatic settle(input int n, input int budget);
    int k = 0;
    while (got_len.size() < n && k < budget) begin
      tick();
      k++;
    end
    repeat (6) tick();
  endtask

  // Reference: an address joins the current burst iff it is the previous address
  // plus one beat, does not start a new 4 KiB page, and the burst has room.
  task automatic build_expected(input int maxl);
    logic [AW-1:0] start;
    int beats;
    exp_len.delete();
    exp_base.delete();
    start = '0;
    beats = 0;
    for (int i = 0; i < popped.size(); i++) begin
      if (i > 0 && popped[i] == popped[i-1] + 64'd64 && popped[i][BL-1:0] != 0 && beats <= maxl) begin
        beats++;
      end else begin
        if (i > 0) begin
          exp_len.push_back(LW'(beats - 1));
          exp_base.push_back(start);
        end
        start = popped[i];
        beats = 1;
      end
    end
    if (popped.size() > 0) begin
      exp_len.push_back(LW'(beats - 1));
      exp_base.push_back(start);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int ml, mw, r;
    rst_n = 1'b0;
    max_wait_time = 4'd3;
    max_burst_len = 8'd15;
    addr_empty_n = 1'b0;
    addr_dout = '0;
    addr_full_n = 1'b1;
    burst_len_full_n = 1'b1;

    // Four contiguous beats, then idle: single burst after the timeout.
    do_reset();
    max_burst_len = 8'd15; max_wait_time = 4'd3;
    push(64'h0, 0); push(64'h40, 0); push(64'h80, 0); push(64'hC0, 0);
    settle(1, 40);
    chk("t26_count", got_len.size(), 1);
    chk("t26_len", gl(0), 3);
    chk("t26_base", gb(0), 0);
    chk("t26_pops", pop_cyc.size(), 4);
    chk("t26_b2b", pc(3) - pc(0), 3);
    chk("t26_latency", ec(0) - pc(3), 4);

    // 4 KiB page crossing splits the stream.
    do_reset();
    push(64'hF80, 0); push(64'hFC0, 0); push(64'h1000, 0); push(64'h1040, 0);
    settle(2, 40);
    chk("t27_count", got_len.size(), 2);
    chk("t27_len0", gl(0), 1);
    chk("t27_base0", gb(0), 64'hF80);
    chk("t27_len1", gl(1), 1);
    chk("t27_base1", gb(1), 64'h1000);
    chk("t27_same_cycle", ec(0) - pc(2), 0);

    // Length cap with continuous popping.
    do_reset();
    max_burst_len = 8'd7;
    for (int i = 0; i < 20; i++) push(64'(i) * 64'd64, 0);
    settle(3, 60);
    chk("t28_count", got_len.size(), 3);
    chk("t28_len0", gl(0), 7);  chk("t28_base0", gb(0), 64'h0);
    chk("t28_len1", gl(1), 7);  chk("t28_base1", gb(1), 64'h200);
    chk("t28_len2", gl(2), 3);  chk("t28_base2", gb(2), 64'h400);
    chk("t28_no_bubble", pc(19) - pc(0), 19);

    // Non-contiguous pair.
    do_reset();
    max_burst_len = 8'd15;
    push(64'h0, 0); push(64'h100, 0);
    settle(2, 40);
    chk("t29_count", got_len.size(), 2);
    chk("t29_len0", gl(0), 0);  chk("t29_base0", gb(0), 64'h0);
    chk("t29_same_cycle", ec(0) - pc(1), 0);
    chk("t29_len1", gl(1), 0);  chk("t29_base1", gb(1), 64'h100);

    // Downstream full holds a pending flush.
    do_reset();
    push(64'h0, 0); push(64'h100, 0);
    tick();
    chk("t30_first_pop", pop_cyc.size(), 1);
    full_force = 5;
    repeat (5) tick();
    chk("t30_held_read", pop_cyc.size(), 1);
    chk("t30_held_write", got_len.size(), 0);
    tick();
    chk("t30_emit", got_len.size(), 1);
    chk("t30_pop2", pop_cyc.size(), 2);
    chk("t30_base0", gb(0), 64'h0);
    settle(2, 40);
    chk("t30_base1", gb(1), 64'h100);

    // Asynchronous reset mid-burst discards the partial burst.
    do_reset();
    push(64'h0, 0); push(64'h40, 0); push(64'h80, 0);
    repeat (3) tick();
    chk("t31_pops", pop_cyc.size(), 3);
    @(negedge clk);
    addr_empty_n = 1'b1;
    addr_dout = 64'hC0;
    rst_n = 1'b0;
    #2;
    chk("t31_read", addr_read, 0);
    chk("t31_write", addr_write, 0);
    chk("t31_din", addr_din, 0);
    chk("t31_blen", burst_len_din, 0);
    @(negedge clk);
    addr_empty_n = 1'b0;
    rst_n = 1'b1;
    push(64'hC0, 0);
    settle(1, 40);
    chk("t31_count", got_len.size(), 1);
    chk("t31_len", gl(0), 0);
    chk("t31_base", gb(0), 64'hC0);

    // Cap lowered mid-burst takes effect immediately.
    do_reset();
    max_burst_len = 8'd15; max_wait_time = 4'd2;
    for (int i = 0; i < 8; i++) push(64'h2000 + 64'(i) * 64'd64, 0);
    repeat (2) tick();
    max_burst_len = 8'd1;
    settle(4, 60);
    chk("t21_count", got_len.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t21_len", gl(i), 1);
      chk("t21_base", gb(i), 64'h2000 + 64'(i) * 64'd128);
    end

    // Randomized streams with gaps and downstream backpressure.
    for (int run = 0; run < 3; run++) begin
      int k;
      do_reset();
      ml = $urandom_range(15);
      mw = $urandom_range(5);
      max_burst_len = LW'(ml);
      max_wait_time = 4'(mw);
      a = '0;
      for (int i = 0; i < 250; i++) begin
        r = $urandom_range(99);
        if (i == 0 || r < 15)
          a = ({$urandom, $urandom} & ~64'hFFF) | (64'hC00 + 64'($urandom_range(15) << 6));
        else if (r < 20) a = 64'hFFFF_FFFF_FFFF_FF40;
        else if (r < 25) a = a + 64'd64 + 64'($urandom_range(63));
        else if (r < 30) a = a;
        else             a = a + 64'd64;
        push(a, $urandom_range(mw));
      end
      bp_pct = 30;
      k = 0;
      while (q.size() > 0 && k < 20000) begin
        tick();
        k++;
      end
      bp_pct = 0;
      repeat (40) tick();
      chk("rnd_drained", q.size(), 0);
      chk("rnd_popped", popped.size(), 250);
      build_expected(ml);
      chk("rnd_count", got_len.size(), exp_len.size());
      for (int i = 0; i < exp_len.size(); i++) begin
        chk("rnd_len", gl(i), exp_len[i]);
        chk("rnd_base", gb(i), exp_base[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/detect_burst_4k.md
DETECT_BURST_4K -- requirements
Module: detect_burst_4k

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, byte-address width.
REQ-002 SHALL have parameter DataWidthBytesLog, default 6, log2 of bytes per beat.
REQ-003 SHALL have parameter WaitTimeWidth, default 4, width of max_wait_time and the idle counter.
REQ-004 SHALL have parameter BurstLenWidth, default 8, width of burst length fields (AXI LEN encoding, beats-1).
REQ-005 SHALL have parameter BoundaryLog, default 12, log2 of the byte boundary no burst may cross.
REQ-006 SHALL have ports (name direction width meaning), clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- max_wait_time  in  WaitTimeWidth  idle cycles tolerated before flushing a partial burst
- max_burst_len  in  BurstLenWidth  burst cap, beats-1
- addr_dout  in  AddrWidth  head of input address FIFO
- addr_empty_n  in  1  input FIFO non-empty
- addr_read  out  1  pop input FIFO
- addr_din  out  BurstLenWidth+AddrWidth  {len, base address} of emitted burst
- addr_full_n  in  1  burst address FIFO has space
- addr_write  out  1  push burst address FIFO
- burst_len_din  out  BurstLenWidth  len of emitted burst
- burst_len_full_n  in  1  length FIFO has space
- burst_len_write  out  1  push length FIFO

Function
REQ-007 SHALL implement two states, IDLE and ACCUM, with registers base, next (base + beats*2^DataWidthBytesLog), len, wait_cnt.
REQ-008 IDLE: addr_empty_n=1 -> addr_read=1, base=addr_dout, next=addr_dout+2^DataWidthBytesLog, len=0, wait_cnt=0, go ACCUM; else remain IDLE, no reads or writes.
REQ-009 ACCUM extend condition: addr_empty_n=1 AND addr_dout==next AND len<max_burst_len AND next[BoundaryLog-1:0]!=0.
REQ-010 On extend: addr_read=1, len+=1, next+=2^DataWidthBytesLog, wait_cnt=0, same cycle, no emission.
REQ-011 ACCUM flush condition: (addr_empty_n=1 AND extend condition false) OR (addr_empty_n=0 AND wait_cnt>=max_wait_time).
REQ-012 ACCUM with addr_empty_n=0 and wait_cnt<max_wait_time: wait_cnt+=1, saturating at all-ones.
REQ-013 Emission occurs only when flush condition AND addr_full_n AND burst_len_full_n; then addr_write=1 and burst_len_write=1 in the same cycle, addr_din={len,base}, burst_len_din=len.
REQ-014 Flush condition true with either FIFO full: hold all state, no read, no write, wait_cnt frozen.
REQ-015 Emission with addr_empty_n=1: same cycle addr_read=1 and new burst loaded per REQ-008, stay ACCUM (back-to-back, no bubble).
REQ-016 Emission with addr_empty_n=0: go IDLE.
REQ-017 addr_read SHALL never assert when addr_empty_n=0; addr_write and burst_len_write SHALL always assert together.
REQ-018 addr_read, addr_write, burst_len_write SHALL be combinational from state and inputs; addr_din, burst_len_din SHALL be driven from registers only.
REQ-019 Address arithmetic SHALL be modulo 2^AddrWidth; a burst SHALL never span a 2^BoundaryLog-byte boundary; a burst SHALL never exceed max_burst_len+1 beats.
REQ-020 Address low DataWidthBytesLog bits SHALL pass through unchanged and take part in the REQ-009 comparison.
REQ-021 max_wait_time and max_burst_len SHALL be sampled every cycle; a change mid-burst applies from that cycle.
REQ-022 Every address popped SHALL appear in exactly one emitted burst, in input order.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE; base, next, len, wait_cnt=0; addr_din, burst_len_din=0; addr_read, addr_write, burst_len_write=0.
REQ-024 A partial burst in ACCUM at reset SHALL be discarded without emission.
REQ-025 The first pop SHALL occur no earlier than the first rising clk edge after rst_n deasserts.

Verification
REQ-026 Addresses 0x0,0x40,0x80,0xC0 back-to-back, max_burst_len=15, max_wait_time=3, FIFO then empty -> one emission {len=3, base=0x0} exactly 4 idle cycles after last pop.
REQ-027 Addresses 0xF80,0xFC0,0x1000,0x1040 -> {len=1, base=0xF80} then {len=1, base=0x1000}; no burst crosses 0x1000.
REQ-028 20 consecutive addresses from 0x0, max_burst_len=7 -> bursts len 7 @0x0, len 7 @0x200, len 3 @0x400; pop every cycle, no bubble at emission.
REQ-029 Addresses 0x0,0x100 back-to-back -> {0,0x0} emitted in the cycle 0x100 is popped; then {0,0x100} after timeout.
REQ-030 Flush pending with addr_full_n=0 for 5 cycles -> no read, no write, state held; emission on the first cycle addr_full_n=1.
REQ-031 rst_n low mid-ACCUM (len=2) for one cycle -> all outputs 0 immediately, no emission of the partial burst, next address starts a new burst with len=0.
